// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the funct3 access-size encodings, the arbiter FSM state encoding
// and the alignment check used to reject accesses before they reach memory.
package mem_pkg;

  // funct3 access-size encodings
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_READ_WAIT = 2'd2;
  localparam logic [1:0] ST_ERROR     = 2'd3;

  // An access is rejected when it is not naturally aligned for its size.
  // Sizes with no defined encoding (011, 110, 111) are rejected outright.
  function automatic logic is_misaligned(input logic [2:0] mode,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (mode)
      MODE_B, MODE_BU: bad = 1'b0;
      MODE_H, MODE_HU: bad = addr_lo[0];
      MODE_W:          bad = (addr_lo != 2'b00);
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way arbiter.
// Ports:
//   req_i[1:0]        request per port
//   last_grant_i      port that won the previous arbitration
//   fixed_priority_i  1 = port 0 always wins a tie
//   gnt_o[1:0]        one-hot grant (or zero when nobody requests)
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       fixed_priority_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      // On a tie, round-robin favours whichever port did not win last.
      gnt_o = (fixed_priority_i || last_grant_i) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data_memory port between the core load/store path
// (port 0) and the program-loader/debug path (port 1).
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   pN_req/we/addr/wdata/mode         request from port N (held until gnt)
//   pN_gnt                            request accepted this cycle (IDLE only)
//   pN_done/err/rdata                 one-cycle completion, error flag, load data
//   dm_address/write_data/we/mode     drive data_memory
//   dm_read_data                      data from data_memory, READ_LATENCY after address
module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_mode,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_mode,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  output logic        dm_we,
  output logic [2:0]  dm_mode,
  input  logic [31:0] dm_read_data
);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  mode_q, mode_d;
  logic        port_q, port_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic [1:0]  arb_gnt;
  logic        sel_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_mode;

  rr_arbiter2 u_arb (
    .req_i           ({p1_req, p0_req}),
    .last_grant_i    (last_grant_q),
    .fixed_priority_i(FIXED_PRIORITY),
    .gnt_o           (arb_gnt)
  );

  // Grants are only offered in IDLE; reset also masks them so every
  // output reads zero while reset is asserted.
  assign p0_gnt = (state_q == ST_IDLE) && !rst && arb_gnt[0];
  assign p1_gnt = (state_q == ST_IDLE) && !rst && arb_gnt[1];

  assign sel_port  = arb_gnt[1];
  assign sel_we    = sel_port ? p1_we    : p0_we;
  assign sel_addr  = sel_port ? p1_addr  : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata : p0_wdata;
  assign sel_mode  = sel_port ? p1_mode  : p0_mode;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    port_d       = port_q;
    cnt_d        = cnt_q;
    // Completion outputs are pulses: they default back to zero every cycle.
    done_d       = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = 32'h0;
    rdata1_d     = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          mode_d       = sel_mode;
          port_d       = sel_port;
          last_grant_d = sel_port;
          if (is_misaligned(sel_mode, sel_addr[1:0])) begin
            state_d = ST_ERROR;
          end else if (sel_we) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ_WAIT;
            cnt_d   = 3'(READ_LATENCY);
          end
        end
      end
      ST_WRITE: begin
        done_d[port_q] = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_READ_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Memory data becomes valid in the last wait cycle; capture it so
        // it appears alongside done.
        if (cnt_q == 3'd1) begin
          done_d[port_q] = 1'b1;
          if (port_q) rdata1_d = dm_read_data;
          else        rdata0_d = dm_read_data;
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        done_d[port_q] = 1'b1;
        err_d[port_q]  = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      mode_q       <= 3'b000;
      port_q       <= 1'b0;
      cnt_q        <= 3'd0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mode_q       <= mode_d;
      port_q       <= port_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign p0_done  = done_q[0];
  assign p1_done  = done_q[1];
  assign p0_err   = err_q[0];
  assign p1_err   = err_q[1];
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

  // Memory sees nothing outside WRITE/READ_WAIT, so IDLE and ERROR read zero.
  always_comb begin
    dm_address    = 32'h0;
    dm_write_data = 32'h0;
    dm_mode       = 3'b000;
    dm_we         = 1'b0;
    if (state_q == ST_WRITE) begin
      dm_address    = addr_q;
      dm_write_data = wdata_q;
      dm_mode       = mode_q;
      dm_we         = we_q;
    end else if (state_q == ST_READ_WAIT) begin
      dm_address = addr_q;
      dm_mode    = mode_q;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single data_memory port between two requesters: port 0 is the core load/store path and port 1 is the program-loader/debug path. The block sits between the requesters and data_memory. It performs round-robin or fixed-priority arbitration, captures each request, sequences a write or a multi-cycle read, and returns a one-cycle completion pulse. It also rejects misaligned accesses before they reach memory.

Parameters:
READ_LATENCY, 1, cycles from the address being presented on dm_address to dm_read_data being valid; legal range 1..7.
FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins a tie.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 request; held high with fields stable until p0_gnt is sampled high
p0_we  in  1  port 0 write enable (1 = store, 0 = load)
p0_addr  in  32  port 0 byte address
p0_wdata  in  32  port 0 store data, right-aligned
p0_mode  in  3  port 0 access size, funct3 encoding (000 b, 001 h, 010 w, 100 bu, 101 hu)
p0_gnt  out  1  port 0 request accepted this cycle (combinational, IDLE state only)
p0_done  out  1  port 0 one-cycle completion pulse
p0_err  out  1  port 0 misaligned-access flag, valid with p0_done
p0_rdata  out  32  port 0 load data, valid with p0_done
p1_req, p1_we, p1_addr, p1_wdata, p1_mode, p1_gnt, p1_done, p1_err, p1_rdata  same as port 0, for port 1
dm_address  out  32  to data_memory
dm_write_data  out  32  to data_memory
dm_we  out  1  to data_memory; high for exactly one cycle per accepted aligned store
dm_mode  out  3  to data_memory
dm_read_data  in  32  from data_memory

Behaviour:
- States: IDLE, WRITE, READ_WAIT, ERROR.
- Reset (async, any state): state=IDLE; last_grant=1; every output =0; latched request regs =0.
- IDLE: winner = the only requester, or on a tie: port 0 if FIXED_PRIORITY=1, else the port that is not last_grant.
  - pN_gnt=1 combinationally for the winner only.
  - At the clock edge: latch we/addr/wdata/mode/port; set last_grant=winner.
  - Next state: ERROR if misaligned, else WRITE if we=1, else READ_WAIT with wait counter=READ_LATENCY.
- Misaligned: mode[1:0]=01 with addr[0]!=0, or mode[1:0]=10 with addr[1:0]!=0. Mode 011, 110 and 111 are also treated as errors.
- WRITE: dm_* driven from latched regs; dm_we=1 for this cycle only; next state IDLE; pN_done=1 on the following cycle, pN_rdata=0.
- READ_WAIT: dm_address/dm_mode held from latched regs; dm_we=0; counter decrements each cycle.
  - When the counter reaches 1, dm_read_data is registered into pN_rdata.
  - The next cycle: pN_done=1 and state=IDLE.
- ERROR: no dm_* activity (dm_we=0); next cycle pN_done=1, pN_err=1, pN_rdata=0; state=IDLE.
- Latency (gnt in cycle T):
  - Store: dm_we at T+1, done at T+2.
  - Load: address presented T+1..T+READ_LATENCY, done and rdata at T+READ_LATENCY+1.
  - Error: done at T+2.
- The state is IDLE in the cycle done is high, so a new grant may occur in the same cycle as the previous done.
- done, err and rdata go only to the owning port. The other port's outputs stay 0, and rdata holds 0 when done=0.
- A requester dropping req before gnt is legal; nothing is latched. req while not IDLE is ignored (gnt=0).
- dm_address/dm_write_data/dm_mode read 0 in IDLE.

Decomposition:
- Shared package (mem_pkg): funct3 size encodings MODE_B/H/W/BU/HU, arbiter state encoding, misalignment function.
- Sub-module rr_arbiter2 (combinational 2-way pick from req[1:0], last_grant, fixed_priority → gnt[1:0]).
- Top holds the FSM, latch registers and latency counter.

Test Plan:
- Single store: p0 we=1, addr=0x10, wdata=0xDEADBEEF, mode=010 → p0_gnt in cycle T, dm_we=1 only at T+1 with dm_address=0x10, p0_done at T+2, p1 outputs 0.
- Load latency: READ_LATENCY=3, memory returns 0x12345678, p1 load addr=0x20 → p1_done and p1_rdata=0x12345678 at T+4, dm_we never high.
- Round-robin: both req held continuously for 4 accesses → grants alternate 0,1,0,1 (first tie → port 0). With FIXED_PRIORITY=1 → 0,0,0,0.
- Misaligned: p0 halfword addr=0x3, and separately word addr=0x6 → no dm_we, p0_done+p0_err at T+2. Byte addr=0x3 → normal completion, err=0.
- Back-to-back: p0 store done in cycle D while p1 req high → p1_gnt in cycle D, dm_we for p1 at D+1.
- Reset mid-read: assert rst during READ_WAIT → all outputs 0 immediately, no done pulse. After release, the first tie → port 0.
